// File: rtl/xadc_drp_scheduler.sv
// XADC DRP read scheduler: reads the X then Y joystick aux channels once per
// sample round and holds the 12-bit results for downstream consumers.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   asynchronous reset, active-low
//   clr_err      in   1   sync pulse, clears timeout_err and overrun_err
//   drp_do       in   16  DRP read data, result in [15:4]
//   drp_drdy     in   1   DRP data-ready strobe
//   drp_den      out  1   DRP enable, one-cycle pulse per read
//   drp_daddr    out  7   DRP address, held from den until drdy/timeout
//   drp_dwe      out  1   DRP write enable, tied low
//   adc_x_out    out  12  last good X sample
//   adc_y_out    out  12  last good Y sample
//   sample_valid out  1   one-cycle pulse when a round completes
//   busy         out  1   round in progress
//   timeout_err  out  1   sticky: a read saw no drdy in time
//   overrun_err  out  1   sticky: a sample tick arrived while busy
module xadc_drp_scheduler #(
    parameter logic [6:0] ADDR_X     = 7'h16,
    parameter logic [6:0] ADDR_Y     = 7'h1E,
    parameter int         SAMPLE_DIV = 100000,
    parameter int         TIMEOUT    = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_err,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        drp_dwe,
    output logic [11:0] adc_x_out,
    output logic [11:0] adc_y_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_X,
        S_WAIT_X,
        S_REQ_Y,
        S_WAIT_Y,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_div;
    logic [7:0]      r_wcnt;
    logic            w_tick;
    logic            w_wcnt_hit;
    logic            w_cap_x;
    logic            w_cap_y;
    logic            w_timeout;
    logic            w_overrun;
    logic            w_unused_lsb;

    // Low nibble of the DRP word carries no sample bits.
    assign w_unused_lsb = ^drp_do[3:0];

    assign w_tick     = (r_div == DW'(SAMPLE_DIV - 1));
    assign w_wcnt_hit = (r_wcnt == 8'(TIMEOUT - 1));
    assign busy       = (r_state != S_IDLE);
    assign w_overrun  = w_tick && busy;
    assign drp_dwe    = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        drp_den      = 1'b0;
        drp_daddr    = 7'h00;
        sample_valid = 1'b0;
        w_cap_x      = 1'b0;
        w_cap_y      = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick) w_next = S_REQ_X;
            end
            S_REQ_X: begin
                drp_den   = 1'b1;
                drp_daddr = ADDR_X;
                w_next    = S_WAIT_X;
            end
            S_WAIT_X: begin
                drp_daddr = ADDR_X;
                // A reply on the last allowed cycle still counts.
                if (drp_drdy) begin
                    w_cap_x = 1'b1;
                    w_next  = S_REQ_Y;
                end else if (w_wcnt_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_REQ_Y;
                end
            end
            S_REQ_Y: begin
                drp_den   = 1'b1;
                drp_daddr = ADDR_Y;
                w_next    = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                drp_daddr = ADDR_Y;
                if (drp_drdy) begin
                    w_cap_y = 1'b1;
                    w_next  = S_DONE;
                end else if (w_wcnt_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                sample_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
        end else if (r_state == S_REQ_X || r_state == S_REQ_Y) begin
            r_wcnt <= '0;
        end else if (r_state == S_WAIT_X || r_state == S_WAIT_Y) begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_x_out <= '0;
            adc_y_out <= '0;
        end else begin
            if (w_cap_x) adc_x_out <= drp_do[15:4];
            if (w_cap_y) adc_y_out <= drp_do[15:4];
        end
    end

    // A new error in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (w_timeout)    timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
            if (w_overrun)    overrun_err <= 1'b1;
            else if (clr_err) overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Directed bench for xadc_drp_scheduler with a small DRP reply model.
// Cycle numbers count posedges since reset release.
module tb_xadc_drp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_dwe;
    logic [11:0] adc_x_out;
    logic [11:0] adc_y_out;
    logic        sample_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // DRP model: reply arrives dly+1 cycles after the den cycle; dly<0 = silent.
    int          dly_x = 3;
    int          dly_y = 3;
    logic [15:0] do_x = 16'hABC0;
    logic [15:0] do_y = 16'hABC0;
    int          cnt = 0;
    logic        m_drdy = 1'b0;
    logic [15:0] m_do = 16'h0;
    logic        spur = 1'b0;

    int          den_cyc[$];
    logic [6:0]  den_adr[$];
    int          val_cyc[$];

    assign drp_drdy = m_drdy | spur;
    assign drp_do   = spur ? 16'hFFF0 : m_do;

    xadc_drp_scheduler #(
        .ADDR_X(7'h16),
        .ADDR_Y(7'h1E),
        .SAMPLE_DIV(16),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .clr_err(clr_err),
        .drp_do(drp_do),
        .drp_drdy(drp_drdy),
        .drp_den(drp_den),
        .drp_daddr(drp_daddr),
        .drp_dwe(drp_dwe),
        .adc_x_out(adc_x_out),
        .adc_y_out(adc_y_out),
        .sample_valid(sample_valid),
        .busy(busy),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int d;
        if (!rst_n) begin
            cnt = 0;
            m_drdy = 1'b0;
        end else if (drp_den) begin
            d = (drp_daddr == 7'h16) ? dly_x : dly_y;
            m_do = (drp_daddr == 7'h16) ? do_x : do_y;
            cnt = (d < 0) ? 0 : d + 1;
            m_drdy = 1'b0;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            m_drdy = (cnt == 0);
        end else begin
            m_drdy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (drp_den) begin
                den_cyc.push_back(cyc);
                den_adr.push_back(drp_daddr);
            end
            if (sample_valid) val_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int n);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (cyc < n && b < 1000);
        chk("wait_cycle", cyc, n);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_den"}, drp_den, 0);
        chk({tag, "_daddr"}, drp_daddr, 0);
        chk({tag, "_dwe"}, drp_dwe, 0);
        chk({tag, "_x"}, adc_x_out, 0);
        chk({tag, "_y"}, adc_y_out, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_oerr"}, overrun_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_outs("rst");
        rst_n = 1'b1;

        // Round 1: tick at 15, den X 16, den Y 21, valid 26.
        wait_until(18);
        chk("r1_hold_addr", drp_daddr, 7'h16);
        chk("r1_busy", busy, 1);
        wait_until(27);
        chk("r1_nden", den_cyc.size(), 2);
        chk("r1_den_x", den_cyc[0], 16);
        chk("r1_adr_x", den_adr[0], 7'h16);
        chk("r1_den_y", den_cyc[1], 21);
        chk("r1_adr_y", den_adr[1], 7'h1E);
        chk("r1_valid", val_cyc[0], 26);
        chk("r1_x", adc_x_out, 12'hABC);
        chk("r1_y", adc_y_out, 12'hABC);
        chk("r1_terr", timeout_err, 0);
        chk("r1_oerr", overrun_err, 0);

        // Spurious drdy while idle must not be captured.
        wait_until(28);
        spur = 1'b1;
        wait_until(29);
        spur = 1'b0;
        wait_until(30);
        chk("spur_x", adc_x_out, 12'hABC);
        chk("spur_y", adc_y_out, 12'hABC);

        // Round 2: X silent -> Y den after 8 wait cycles.
        dly_x = -1;
        dly_y = 3;
        do_y = 16'h1230;
        wait_until(40);
        chk("r2_terr_pre", timeout_err, 0);
        wait_until(47);
        chk("r2_den_x", den_cyc[2], 32);
        chk("r2_den_y", den_cyc[3], 41);
        chk("r2_valid", val_cyc[1], 46);
        chk("r2_terr", timeout_err, 1);
        chk("r2_x", adc_x_out, 12'hABC);
        chk("r2_y", adc_y_out, 12'h123);

        // Round 3: drdy on the last timeout cycle wins.
        clr_err = 1'b1;
        dly_x = 7;
        do_x = 16'h5550;
        do_y = 16'h6660;
        wait_until(48);
        clr_err = 1'b0;
        chk("clr1_terr", timeout_err, 0);
        wait_until(63);
        chk("r3_den_y", den_cyc[5], 57);
        chk("r3_valid", val_cyc[2], 62);
        chk("r3_x", adc_x_out, 12'h555);
        chk("r3_y", adc_y_out, 12'h666);
        chk("r3_terr", timeout_err, 0);

        // Round 4: both silent -> round outlasts the tick period.
        dly_x = -1;
        dly_y = -1;
        wait_until(80);
        chk("r4_oerr", overrun_err, 1);
        chk("r4_busy", busy, 1);
        wait_until(90);
        chk("r4_nden", den_cyc.size(), 8);
        chk("r4_den_y", den_cyc[7], 73);
        chk("r4_valid", val_cyc[3], 82);
        chk("r4_terr", timeout_err, 1);
        chk("r4_x", adc_x_out, 12'h555);
        clr_err = 1'b1;
        wait_until(91);
        clr_err = 1'b0;
        chk("clr2_terr", timeout_err, 0);
        chk("clr2_oerr", overrun_err, 0);

        // Round 5: reset lands in WAIT_Y.
        dly_x = 3;
        dly_y = 3;
        do_x = 16'h7770;
        do_y = 16'h8880;
        wait_until(103);
        chk("r5_x", adc_x_out, 12'h777);
        chk("r5_addr", drp_daddr, 7'h1E);
        #1 rst_n = 1'b0;
        #1 chk_idle_outs("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_until(17);
        chk("post_nden", den_cyc.size(), 11);
        chk("post_den", den_cyc[10], 16);
        chk("post_nval", val_cyc.size(), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
